multicycle_controller: RTL
==========================

# multicycle_controller

Multicycle successor to the single-cycle ARM decoder: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It owns the NZCV flag register and condition check, and adds an iterative multiply stall of parametrised length. It sits between the instruction register/ALU flags and the multicycle datapath muxes and write enables.

## Interface
- MUL_CYCLES, 4, cycles spent in EXECM; legal 1..15.
- MUL_EN, 1, 1 = decode MUL (Op=00, Instr[25:24]=00, Instr[7:4]=1001); 0 = MUL encodings decode as data-processing register.
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  asynchronous, active-high.
- Instr  in  32  IR contents; valid from DECODE onward.
- ALUFlags  in  4  NZCV from the ALU, current cycle.
- IRWrite, PCWrite, RegWrite, MemWrite, MulEn  out  1 each  enables.
- AdrSrc  out  1  0 = PC, 1 = ALU result register.
- ALUSrcA  out  2  00 = Rn, 01 = PC, 10 = ALUOut.
- ALUSrcB  out  2  00 = shifted Rm, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result direct.
- ALUControl  out  4  ARM Funct[4:1] code; 0100 = ADD.
- ShiftOp  out  3  000 none, 001 LSL, 010 LSR, 011 ASR, 100 RRX, 101 ROR.
- ImmSrc, RegSrc  out  2 each  same encoding as the single-cycle decoder.
- Flags  out  4  registered NZCV.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, EXECM, ALUWB, BRANCH.
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD. Next state is DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. No enables. Computes CondEx from the registered Flags and Instr[31:28].
  - CondEx=0 goes to FETCH.
  - Otherwise: Op=01 goes to MEMADR; Op=10 goes to BRANCH.
  - Op=00 goes to EXECM if MUL and MUL_EN, else EXECI if Instr[25], else EXECR.
  - Op=11 goes to FETCH (NOP).
- Conditions: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&N==V, LE Z|N!=V, AL 1. Code 1111 gives 0.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Instr[20]=1 goes to MEMRD, else MEMWR.
- MEMRD: AdrSrc=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWR: AdrSrc=1, MemWrite=1, then FETCH.
- EXECR / EXECI: ALUSrcA=00, ALUSrcB=00 or 01, ALUControl=Instr[24:21].
  - Compare ops (Instr[24:23]=10) go to FETCH; others go to ALUWB.
- ShiftOp, EXECR only:
  - 000 if Instr[11:4]=0.
  - Otherwise Instr[6:5]=00/01/10 gives 001/010/011.
  - Instr[6:5]=11 gives 100 if Instr[11:7]=0, else 101.
  - ShiftOp=000 in all other states.
- EXECM: MulEn=1. A down-counter loads MUL_CYCLES-1 on entry and exits to ALUWB when it reaches 0.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=1, then FETCH.
- PC writeback: in ALUWB/MEMWB with Instr[15:12]=1111, PCWrite=1 alongside RegWrite.
- Flag update, clocked at the end of EXECR/EXECI, and of the last EXECM cycle, only when Instr[20]=1:
  - NZ are loaded from ALUFlags[3:2].
  - CV are loaded from ALUFlags[1:0] only for SUB 0010, RSB 0011, ADD 0100, CMP 1010, CMN 1011; never for MUL.
- ALUControl is 0100 in all non-execute states and in EXECM.

## Timing
- Latencies:
  - LDR: 5 cycles.
  - STR, DP, MUL-less ALU ops: 4 cycles.
  - Compare and B: 3 cycles.
  - MUL: 3+MUL_CYCLES cycles.
  - Failed condition and NOP: 2 cycles.
- Reset asserted: state=FETCH, Flags=0000, counter=0. IRWrite, PCWrite, RegWrite, MemWrite and MulEn are forced 0; all other outputs take their FETCH values.
- Reset deasserted: first FETCH with enables active on the first rising edge.
- Reset mid-instruction, including mid-EXECM: immediate return to FETCH. Flags are cleared, and no pending write issues.
- A flag write and the CondEx of the next instruction never overlap: DECODE always follows at least one FETCH.

## Test plan
- Reset, then release with Instr=E0810002 (ADD r0,r1,r2): states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4; Flags stay 0000.
- SUBS with ALUFlags=0110, then Instr=0A000001 (BEQ): Flags=0110. BEQ passes: BRANCH with PCWrite=1, 3 cycles total.
- Instr=1A000001 (BNE) with Z=1: DECODE returns to FETCH. No PCWrite in DECODE; 2 cycles total.
- LDR E5910004 takes 5 cycles with ResultSrc=01 in MEMWB. STR E5810004 gives MemWrite=1 only in MEMWR.
- MUL E0000291 with MUL_CYCLES=4: MulEn high exactly 4 cycles, then ALUWB. Reset asserted on the 2nd EXECM cycle gives FETCH immediately and no RegWrite.
- Shift decode E1A00101 (LSL #2) gives 001; E1A00060 (RRX) gives 100; E1A000E0 (ROR #1) gives 101; immediate forms give 000.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: a Moore FSM that walks each instruction through
// fetch, decode, execute, memory and writeback. It holds the NZCV flag
// register and evaluates the condition field, and stalls in EXECM for a
// parametrised number of cycles while the iterative multiplier runs.
module multicycle_controller #(
  parameter int MUL_CYCLES = 4,
  parameter bit MUL_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MulEn,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  ALUControl,
  output logic [2:0]  ShiftOp,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_EXECM,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [2:0] SH_NONE  = 3'b000;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  flags_q, flags_d;

  // Raw enables before the reset gate.
  logic ir_w, pc_w, reg_w, mem_w, mul_w;

  // Instruction fields.
  logic [1:0]  op;
  logic [3:0]  cmd;
  logic        s_bit;
  logic        imm_form;
  logic        rd_is_pc;
  logic        is_mul;
  logic        is_cmp;
  logic        cv_cmd;
  logic        cond_ex;
  logic        flag_upd;
  logic        unused_instr;

  // Condition-field evaluation against registered NZCV.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    res = z;
      4'h1:    res = ~z;
      4'h2:    res = c;
      4'h3:    res = ~c;
      4'h4:    res = n;
      4'h5:    res = ~n;
      4'h6:    res = v;
      4'h7:    res = ~v;
      4'h8:    res = c & ~z;
      4'h9:    res = ~c | z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = ~z & (n == v);
      4'hD:    res = z | (n != v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Shifter operation implied by the register-operand shift field.
  function automatic logic [2:0] shift_decode(input logic [31:0] ins);
    logic [2:0] sh;
    if (ins[11:4] == 8'h00) begin
      sh = SH_NONE;
    end else begin
      case (ins[6:5])
        2'b00:   sh = 3'b001;
        2'b01:   sh = 3'b010;
        2'b10:   sh = 3'b011;
        default: sh = (ins[11:7] == 5'd0) ? 3'b100 : 3'b101;
      endcase
    end
    return sh;
  endfunction

  assign op       = Instr[27:26];
  assign cmd      = Instr[24:21];
  assign s_bit    = Instr[20];
  assign imm_form = Instr[25];
  assign rd_is_pc = (Instr[15:12] == 4'hF);
  assign is_mul   = MUL_EN && (op == 2'b00) && (Instr[25:24] == 2'b00) &&
                    (Instr[7:4] == 4'b1001);
  assign is_cmp   = (Instr[24:23] == 2'b10);
  assign cv_cmd   = (cmd == 4'b0010) || (cmd == 4'b0011) || (cmd == 4'b0100) ||
                    (cmd == 4'b1010) || (cmd == 4'b1011);
  assign cond_ex  = cond_check(Instr[31:28], flags_q);

  // Rn/Rd fields are routed by the datapath, not used for control.
  assign unused_instr = ^{Instr[19:16], Instr[3:0]};

  // Immediate and register-source selects follow the opcode class directly.
  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign Flags  = flags_q;

  // Enables are held low for as long as reset is asserted.
  assign IRWrite  = ir_w  & ~reset;
  assign PCWrite  = pc_w  & ~reset;
  assign RegWrite = reg_w & ~reset;
  assign MemWrite = mem_w & ~reset;
  assign MulEn    = mul_w & ~reset;

  // State, multiply counter and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_ex) begin
          state_d = S_FETCH;
        end else begin
          case (op)
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            2'b00: begin
              if (is_mul)        state_d = S_EXECM;
              else if (imm_form) state_d = S_EXECI;
              else               state_d = S_EXECR;
            end
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_d = s_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXECR,
      S_EXECI:  state_d = is_cmp ? S_FETCH : S_ALUWB;
      S_EXECM:  state_d = (cnt_q == 4'd0) ? S_ALUWB : S_EXECM;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs decoded from the current state (and IR fields).
  always_comb begin
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    mul_w      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    ShiftOp    = SH_NONE;
    unique case (state_q)
      S_FETCH: begin
        ir_w      = 1'b1;
        pc_w      = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        pc_w      = rd_is_pc;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = cmd;
        ShiftOp    = shift_decode(Instr);
      end
      S_EXECI: begin
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b01;
        ALUControl = cmd;
      end
      S_EXECM: begin
        mul_w = 1'b1;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        reg_w     = 1'b1;
        pc_w      = rd_is_pc;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_w      = 1'b1;
      end
      default: ;
    endcase
  end

  // Flags load at the end of the execute step; a multiply never touches C/V.
  assign flag_upd = s_bit && ((state_q == S_EXECR) || (state_q == S_EXECI) ||
                              ((state_q == S_EXECM) && (cnt_q == 4'd0)));

  // Multiply stall counter and NZCV next-state.
  always_comb begin
    cnt_d   = cnt_q;
    flags_d = flags_q;
    if ((state_q == S_DECODE) && (state_d == S_EXECM)) begin
      cnt_d = MUL_LOAD;
    end else if ((state_q == S_EXECM) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (flag_upd) begin
      flags_d[3:2] = ALUFlags[3:2];
      if ((state_q != S_EXECM) && cv_cmd) begin
        flags_d[1:0] = ALUFlags[1:0];
      end
    end
  end

endmodule
